// File: rtl/ex_dest_pipe_pkg.sv
// Shared definitions for the destination-tracking pipeline: the dest_mode
// encodings and the default link register.
package ex_dest_pipe_pkg;

    typedef enum logic [1:0] {
        DEST_L    = 2'd0,
        DEST_R    = 2'd1,
        DEST_LINK = 2'd2,
        DEST_NONE = 2'd3
    } dest_mode_e;

    localparam int LINK_REG_DEFAULT = 31;

endpackage

// File: rtl/ex_dest_pipe_if.sv
// Bundle of instruction-side inputs and tracking/forwarding outputs for ex_dest_pipe.
// The master drives the instruction side; the slave is the pipe itself.
interface ex_dest_pipe_if
    import ex_dest_pipe_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 3
);
    localparam int STAGE_W = $clog2(DEPTH) + 1;

    logic [ADDR_W-1:0]       reg_dest_r_type;
    logic [ADDR_W-1:0]       reg_dest_l_type;
    dest_mode_e              dest_mode;
    logic                    reg_write_in;
    logic                    valid_in;
    logic                    stall;
    logic                    flush;
    logic [ADDR_W-1:0]       src_a;
    logic [ADDR_W-1:0]       src_b;

    logic [ADDR_W-1:0]       reg_dest_selected;
    logic [DEPTH*ADDR_W-1:0] stage_dest;
    logic [DEPTH-1:0]        stage_wr;
    logic                    fwd_a_hit;
    logic                    fwd_b_hit;
    logic [STAGE_W-1:0]      fwd_a_stage;
    logic [STAGE_W-1:0]      fwd_b_stage;

    modport master (
        output reg_dest_r_type, reg_dest_l_type, dest_mode, reg_write_in,
               valid_in, stall, flush, src_a, src_b,
        input  reg_dest_selected, stage_dest, stage_wr,
               fwd_a_hit, fwd_b_hit, fwd_a_stage, fwd_b_stage
    );

    modport slave (
        input  reg_dest_r_type, reg_dest_l_type, dest_mode, reg_write_in,
               valid_in, stall, flush, src_a, src_b,
        output reg_dest_selected, stage_dest, stage_wr,
               fwd_a_hit, fwd_b_hit, fwd_a_stage, fwd_b_stage
    );

endinterface

// File: rtl/ex_dest_fwd_match.sv
// Combinational lookup of one operand address against all in-flight writes;
// reports the youngest (lowest-index) matching stage.
module ex_dest_fwd_match #(
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 3
) (
    input  logic [ADDR_W-1:0]       src,
    input  logic [DEPTH*ADDR_W-1:0] stage_dest,
    input  logic [DEPTH-1:0]        stage_wr,
    output logic                    hit,
    output logic [$clog2(DEPTH):0]  stage
);
    localparam int STAGE_W = $clog2(DEPTH) + 1;

    // NOTE: every output gets a default first so no path through the block leaves it unassigned, which would infer a latch.
    always_comb begin
        hit   = 1'b0;
        stage = '0;
        // Scan oldest to youngest so the lowest matching index is written last and wins.
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (src != '0 && stage_wr[k] && stage_dest[k*ADDR_W +: ADDR_W] == src) begin
                hit   = 1'b1;
                stage = STAGE_W'(k);
            end
        end
    end

endmodule

// File: rtl/ex_dest_pipe.sv
// Destination-register select plus a DEPTH-stage shift array of {dest, write}
// used for hazard detection and operand forwarding lookups.
module ex_dest_pipe
    import ex_dest_pipe_pkg::*;
#(
    parameter int ADDR_W   = 5,
    parameter int DEPTH    = 3,
    parameter int LINK_REG = LINK_REG_DEFAULT
) (
    input logic           clk,
    input logic           rst_n,
    ex_dest_pipe_if.slave bus
);
    localparam logic [ADDR_W-1:0] LINK_DEST = ADDR_W'(LINK_REG);

    logic [ADDR_W-1:0] sel_dest;
    logic              sel_wr;
    logic [ADDR_W-1:0] dest_q [DEPTH];
    logic [ADDR_W-1:0] dest_d [DEPTH];
    logic              wr_q   [DEPTH];
    logic              wr_d   [DEPTH];

    always_comb begin
        case (bus.dest_mode)
            DEST_L:    sel_dest = bus.reg_dest_l_type;
            DEST_R:    sel_dest = bus.reg_dest_r_type;
            DEST_LINK: sel_dest = LINK_DEST;
            default:   sel_dest = '0;
        endcase
        // Writes to register 0 are architecturally discarded, so never track them.
        sel_wr = bus.valid_in & bus.reg_write_in & (bus.dest_mode != DEST_NONE) & (sel_dest != '0);
    end

    always_comb begin
        dest_d = dest_q;
        wr_d   = wr_q;
        if (bus.flush) begin
            dest_d[0] = '0;
            wr_d[0]   = 1'b0;
        end else if (!bus.stall) begin
            dest_d[0] = sel_dest;
            wr_d[0]   = sel_wr;
        end
        for (int k = 1; k < DEPTH; k++) begin
            // A held stage 0 must not also appear in stage 1, so a bubble goes downstream instead.
            if (k == 1 && bus.stall) begin
                dest_d[k] = '0;
                wr_d[k]   = 1'b0;
            end else begin
                dest_d[k] = dest_q[k-1];
                wr_d[k]   = wr_q[k-1];
            end
        end
    end

    // NOTE: the stage array is a set of flops, not a RAM, so every entry is reset; reset must discard in-flight writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                dest_q[k] <= '0;
                wr_q[k]   <= 1'b0;
            end
        end else begin
            // NOTE: non-blocking so each stage samples its neighbour's pre-edge value.
            dest_q <= dest_d;
            wr_q   <= wr_d;
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_out
        assign bus.stage_dest[k*ADDR_W +: ADDR_W] = dest_q[k];
        assign bus.stage_wr[k]                    = wr_q[k];
    end

    assign bus.reg_dest_selected = dest_q[0];

    ex_dest_fwd_match #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_fwd_a (
        .src        (bus.src_a),
        .stage_dest (bus.stage_dest),
        .stage_wr   (bus.stage_wr),
        .hit        (bus.fwd_a_hit),
        .stage      (bus.fwd_a_stage)
    );

    ex_dest_fwd_match #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_fwd_b (
        .src        (bus.src_b),
        .stage_dest (bus.stage_dest),
        .stage_wr   (bus.stage_wr),
        .hit        (bus.fwd_b_hit),
        .stage      (bus.fwd_b_stage)
    );

endmodule

// File: tb/tb_ex_dest_pipe.sv
// Self-checking bench for ex_dest_pipe: directed table, hand-written corner
// sequences and randomized traffic against a queue-based reference model.
module tb_ex_dest_pipe;
    import ex_dest_pipe_pkg::*;

    localparam int ADDR_W  = 5;
    localparam int DEPTH   = 3;
    localparam int STAGE_W = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    ex_dest_pipe_if #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) bus ();

    ex_dest_pipe #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .LINK_REG(31)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Reference model: pipe[0] is the youngest entry, pipe[DEPTH-1] the oldest.
    typedef struct packed {
        logic [ADDR_W-1:0] dest;
        logic              wr;
    } ent_t;

    localparam ent_t BUBBLE = '0;
    ent_t pipe[$];

    typedef struct {
        dest_mode_e        mode;
        logic [ADDR_W-1:0] l;
        logic [ADDR_W-1:0] r;
        logic              rw;
        logic              v;
        logic              fl;
        logic [ADDR_W-1:0] exp_dest;
        logic              exp_wr;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [ADDR_W-1:0] model_sel(input dest_mode_e m,
                                                    input logic [ADDR_W-1:0] l,
                                                    input logic [ADDR_W-1:0] r);
        case (m)
            DEST_L:    return l;
            DEST_R:    return r;
            DEST_LINK: return ADDR_W'(31);
            default:   return '0;
        endcase
    endfunction

    task automatic model_reset();
        pipe.delete();
        for (int k = 0; k < DEPTH; k++) pipe.push_back(BUBBLE);
    endtask

    task automatic model_step();
        ent_t e;
        if (!rst_n) begin
            model_reset();
            return;
        end
        e.dest = model_sel(bus.dest_mode, bus.reg_dest_l_type, bus.reg_dest_r_type);
        e.wr   = bus.valid_in && bus.reg_write_in && (bus.dest_mode != DEST_NONE) && (e.dest != 0);
        if (bus.stall) begin
            pipe.insert(1, BUBBLE);
            if (bus.flush) pipe[0] = BUBBLE;
        end else begin
            pipe.push_front(bus.flush ? BUBBLE : e);
        end
        void'(pipe.pop_back());
    endtask

    task automatic model_fwd(input logic [ADDR_W-1:0] src, output logic hit,
                             output logic [STAGE_W-1:0] stg);
        hit = 1'b0;
        stg = '0;
        if (src != 0) begin
            for (int k = 0; k < DEPTH; k++) begin
                if (!hit && pipe[k].wr && pipe[k].dest == src) begin
                    hit = 1'b1;
                    stg = STAGE_W'(k);
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        logic [DEPTH*ADDR_W-1:0] e_dest;
        logic [DEPTH-1:0]        e_wr;
        logic                    ha, hb;
        logic [STAGE_W-1:0]      sa, sb;
        for (int k = 0; k < DEPTH; k++) begin
            e_dest[k*ADDR_W +: ADDR_W] = pipe[k].dest;
            e_wr[k]                    = pipe[k].wr;
        end
        model_fwd(bus.src_a, ha, sa);
        model_fwd(bus.src_b, hb, sb);
        check({tag, ".stage_dest"},  32'(bus.stage_dest),        32'(e_dest));
        check({tag, ".stage_wr"},    32'(bus.stage_wr),          32'(e_wr));
        check({tag, ".dest_sel"},    32'(bus.reg_dest_selected), 32'(pipe[0].dest));
        check({tag, ".fwd_a_hit"},   32'(bus.fwd_a_hit),         32'(ha));
        check({tag, ".fwd_a_stage"}, 32'(bus.fwd_a_stage),       32'(sa));
        check({tag, ".fwd_b_hit"},   32'(bus.fwd_b_hit),         32'(hb));
        check({tag, ".fwd_b_stage"}, 32'(bus.fwd_b_stage),       32'(sb));
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_src(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b);
        bus.src_a = a;
        bus.src_b = b;
        #1;
    endtask

    task automatic drive(input dest_mode_e m, input logic [ADDR_W-1:0] l, input logic [ADDR_W-1:0] r,
                         input logic rw, input logic v, input logic st, input logic fl);
        bus.dest_mode       = m;
        bus.reg_dest_l_type = l;
        bus.reg_dest_r_type = r;
        bus.reg_write_in    = rw;
        bus.valid_in        = v;
        bus.stall           = st;
        bus.flush           = fl;
    endtask

    task automatic idle(input int n);
        drive(DEST_NONE, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < n; i++) cycle();
    endtask

    function automatic logic [ADDR_W-1:0] dest_at(input int k);
        return bus.stage_dest[k*ADDR_W +: ADDR_W];
    endfunction

    initial begin
        vecs[0] = '{DEST_L,    5'd8, 5'd9, 1'b1, 1'b1, 1'b0, 5'd8,  1'b1};
        vecs[1] = '{DEST_R,    5'd8, 5'd9, 1'b1, 1'b1, 1'b0, 5'd9,  1'b1};
        vecs[2] = '{DEST_LINK, 5'd8, 5'd9, 1'b1, 1'b1, 1'b0, 5'd31, 1'b1};
        vecs[3] = '{DEST_NONE, 5'd8, 5'd9, 1'b1, 1'b1, 1'b0, 5'd0,  1'b0};
        vecs[4] = '{DEST_R,    5'd8, 5'd0, 1'b1, 1'b1, 1'b0, 5'd0,  1'b0};
        vecs[5] = '{DEST_L,    5'd8, 5'd9, 1'b1, 1'b0, 1'b0, 5'd8,  1'b0};
        vecs[6] = '{DEST_R,    5'd8, 5'd9, 1'b0, 1'b1, 1'b0, 5'd9,  1'b0};
        vecs[7] = '{DEST_LINK, 5'd8, 5'd9, 1'b1, 1'b1, 1'b1, 5'd0,  1'b0};

        rst_n = 1'b0;
        drive(DEST_NONE, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        bus.src_a = '0;
        bus.src_b = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset.stage_wr", 32'(bus.stage_wr), 32'd0);
        check("reset.stage_dest", 32'(bus.stage_dest), 32'd0);
        check_all("reset");
        rst_n = 1'b1;

        // Directed select/write-flag table, one-cycle latency.
        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].mode, vecs[i].l, vecs[i].r, vecs[i].rw, vecs[i].v, 1'b0, vecs[i].fl);
            cycle();
            check($sformatf("tbl%0d.dest0", i), 32'(dest_at(0)), 32'(vecs[i].exp_dest));
            check($sformatf("tbl%0d.wr0", i),   32'(bus.stage_wr[0]), 32'(vecs[i].exp_wr));
            set_src('0, 5'd9);
            check($sformatf("tbl%0d.src0_hit", i), 32'(bus.fwd_a_hit), 32'd0);
            check_all($sformatf("tbl%0d", i));
        end

        // Back-to-back writes to the same register: youngest stage wins, then drains.
        idle(DEPTH);
        drive(DEST_L, 5'd5, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        cycle();
        cycle();
        idle(0);
        drive(DEST_NONE, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        set_src(5'd5, 5'd5);
        check("dup.hit_a", 32'(bus.fwd_a_hit), 32'd1);
        check("dup.stage_a", 32'(bus.fwd_a_stage), 32'd0);
        check("dup.stage_b", 32'(bus.fwd_b_stage), 32'd0);
        for (int n = 1; n <= DEPTH; n++) begin
            cycle();
            #1;
            check_all($sformatf("dup.drain%0d", n));
            if (n < DEPTH) begin
                check($sformatf("dup.drain%0d.stage", n), 32'(bus.fwd_a_stage), 32'(n));
                check($sformatf("dup.drain%0d.hit", n), 32'(bus.fwd_a_hit), 32'd1);
            end else begin
                check("dup.cleared", 32'(bus.fwd_a_hit), 32'd0);
            end
        end

        // Stall holds stage 0 and feeds bubbles to stage 1.
        idle(DEPTH);
        drive(DEST_L, 5'd7, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        cycle();
        check("stall.pre.dest0", 32'(dest_at(0)), 32'd7);
        drive(DEST_L, 5'd3, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0);
        for (int n = 0; n < 2; n++) begin
            cycle();
            check($sformatf("stall%0d.dest0", n), 32'(dest_at(0)), 32'd7);
            check($sformatf("stall%0d.wr0", n), 32'(bus.stage_wr[0]), 32'd1);
            check($sformatf("stall%0d.dest1", n), 32'(dest_at(1)), 32'd0);
            check($sformatf("stall%0d.wr1", n), 32'(bus.stage_wr[1]), 32'd0);
            check_all($sformatf("stall%0d", n));
        end
        drive(DEST_NONE, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle();
        check("stall.rel.dest1", 32'(dest_at(1)), 32'd7);
        check("stall.rel.wr1", 32'(bus.stage_wr[1]), 32'd1);

        // Flush while stalled kills stage 0 and bubbles stage 1.
        idle(DEPTH);
        drive(DEST_R, 5'd0, 5'd12, 1'b1, 1'b1, 1'b0, 1'b0);
        cycle();
        set_src(5'd12, 5'd0);
        check("flush.pre.hit", 32'(bus.fwd_a_hit), 32'd1);
        drive(DEST_R, 5'd0, 5'd12, 1'b1, 1'b1, 1'b1, 1'b1);
        cycle();
        #1;
        check("flush.wr", 32'(bus.stage_wr), 32'd0);
        check("flush.dest01", 32'(bus.stage_dest[2*ADDR_W-1:0]), 32'd0);
        check("flush.hit", 32'(bus.fwd_a_hit), 32'd0);
        check_all("flush");

        // Asynchronous reset mid-stream with three valid entries.
        idle(DEPTH);
        for (int n = 0; n < 3; n++) begin
            drive(DEST_L, ADDR_W'(4 + n), 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
            cycle();
        end
        set_src(5'd4, 5'd6);
        check("arst.pre.wr", 32'(bus.stage_wr), 32'h7);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("arst.wr", 32'(bus.stage_wr), 32'd0);
        check("arst.dest", 32'(bus.stage_dest), 32'd0);
        check("arst.hit_a", 32'(bus.fwd_a_hit), 32'd0);
        check("arst.hit_b", 32'(bus.fwd_b_hit), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check_all("arst.held");
        rst_n = 1'b1;
        drive(DEST_R, 5'd0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0);
        cycle();
        check("arst.first.dest0", 32'(dest_at(0)), 32'd9);
        check("arst.first.wr", 32'(bus.stage_wr), 32'd1);

        // Randomized traffic over a small address range so matches are frequent.
        for (int i = 0; i < 400; i++) begin
            drive(dest_mode_e'($urandom_range(0, 3)), ADDR_W'($urandom_range(0, 7)),
                  ADDR_W'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 4) == 0),
                  1'($urandom_range(0, 7) == 0));
            cycle();
            set_src(ADDR_W'($urandom_range(0, 7)), ADDR_W'($urandom_range(0, 7)));
            check_all($sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
